// File: rtl/alu_share_if.sv
// Request/response bundle between the two ALU requesters and alu_share_ctrl.
// Handshake: a transfer occurs on a rising edge where valid and ready are both 1;
// the source holds valid and its payload stable until that edge and never waits on ready.
interface alu_share_if #(
    parameter int WIDTH = 64
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_op0;
    logic [1:0]       req_op1;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_b1;
    logic [1:0]       req_setcc;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_y;
    logic             rsp_zf;
    logic             rsp_sf;
    logic             rsp_of;

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, req_setcc,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid, rsp_id, rsp_y, rsp_zf, rsp_sf, rsp_of
    );

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, req_setcc,
        input  rsp_ready,
        output req_ready,
        output rsp_valid, rsp_id, rsp_y, rsp_zf, rsp_sf, rsp_of
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one combinational ALU between two requesters;
// registers the result with ZF/SF/OF and maintains the architectural condition codes.
module alu_share_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    alu_share_if.slave       bus,
    output logic [1:0]       alu_s,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_of,
    output logic [2:0]       cc,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t           state, state_nx;
    logic             prio;
    logic             grant;
    logic             any_valid;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             setcc_q;
    logic             id_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_y_q;
    logic             rsp_zf_q, rsp_sf_q, rsp_of_q;

    assign any_valid = |bus.req_valid;
    // On a tie the requester not served last wins; otherwise the lone requester.
    assign grant     = (bus.req_valid == 2'b11) ? prio : bus.req_valid[1];

    always_comb begin
        state_nx      = state;
        bus.req_ready = 2'b00;
        case (state)
            IDLE: begin
                if (any_valid && !rst) begin
                    bus.req_ready[grant] = 1'b1;
                    state_nx             = EXEC;
                end
            end
            EXEC:    state_nx = RESP;
            RESP:    if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prio     <= 1'b0;
            op_q     <= 2'b00;
            a_q      <= '0;
            b_q      <= '0;
            setcc_q  <= 1'b0;
            id_q     <= 1'b0;
            rsp_id_q <= 1'b0;
            rsp_y_q  <= '0;
            rsp_zf_q <= 1'b0;
            rsp_sf_q <= 1'b0;
            rsp_of_q <= 1'b0;
            cc       <= 3'b100;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        id_q    <= grant;
                        op_q    <= grant ? bus.req_op1 : bus.req_op0;
                        a_q     <= grant ? bus.req_a1 : bus.req_a0;
                        b_q     <= grant ? bus.req_b1 : bus.req_b0;
                        setcc_q <= bus.req_setcc[grant];
                    end
                end
                EXEC: begin
                    rsp_id_q <= id_q;
                    rsp_y_q  <= alu_y;
                    rsp_zf_q <= (alu_y == '0);
                    rsp_sf_q <= alu_y[WIDTH-1];
                    // Logic ops (S[1]=1) never overflow, whatever the ALU reports.
                    rsp_of_q <= op_q[1] ? 1'b0 : alu_of;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        if (setcc_q) cc <= {rsp_zf_q, rsp_sf_q, rsp_of_q};
                        prio <= ~rsp_id_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_s         = op_q;
    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_zf    = rsp_zf_q;
    assign bus.rsp_sf    = rsp_sf_q;
    assign bus.rsp_of    = rsp_of_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: a behavioural ALU_64_2, a driver issuing
// requests, and a monitor popping expected responses from a scoreboard queue.
module tb_alu_share_ctrl;
    localparam int W  = 64;
    localparam int EW = W + 4;  // {id, zf, sf, of, y}

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    alu_s;
    logic [W-1:0]  alu_a, alu_b, alu_y;
    logic          alu_of;
    logic [2:0]    cc;
    logic [1:0]    dbg_state;

    logic [EW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;

    alu_share_if #(.WIDTH(W)) bus ();

    alu_share_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b),
        .alu_y(alu_y), .alu_of(alu_of), .cc(cc), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Behavioural ALU_64_2; OF is deliberately 1 for logic ops.
    always_comb begin
        alu_y  = '0;
        alu_of = 1'b0;
        case (alu_s)
            2'b00: begin
                alu_y  = alu_a + alu_b;
                alu_of = (alu_a[W-1] == alu_b[W-1]) && (alu_y[W-1] != alu_a[W-1]);
            end
            2'b01: begin
                alu_y  = alu_a - alu_b;
                alu_of = (alu_a[W-1] != alu_b[W-1]) && (alu_y[W-1] != alu_a[W-1]);
            end
            2'b10: begin alu_y = alu_a & alu_b; alu_of = 1'b1; end
            default: begin alu_y = alu_a ^ alu_b; alu_of = 1'b1; end
        endcase
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic id, input logic [W-1:0] y,
                        input logic zf, input logic sf, input logic of);
        exp_q.push_back({id, zf, sf, of, y});
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d y=%h expected no response",
                         bus.rsp_id, bus.rsp_y);
            end else begin
                chk("rsp", {bus.rsp_id, bus.rsp_zf, bus.rsp_sf, bus.rsp_of, bus.rsp_y},
                    exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_port(input int p, input logic [1:0] op,
                              input logic [W-1:0] a, input logic [W-1:0] b, input logic sc);
        bus.req_valid[p] = 1'b1;
        bus.req_setcc[p] = sc;
        if (p == 0) begin
            bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b;
        end else begin
            bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b;
        end
    endtask

    // Waits (bounded) for req_ready[p] at a negedge; leaves the bench just after the accept edge.
    task automatic wait_accept(input int p);
        int t = 0;
        @(negedge clk);
        while (!bus.req_ready[p] && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.req_ready[p]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: port %0d never saw req_ready", p);
        end
        @(posedge clk);
        #1 bus.req_valid[p] = 1'b0;
    endtask

    // One complete transaction with rsp_ready high; checks latency and resulting cc.
    task automatic run_op(input int p, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic sc, input logic [2:0] exp_cc);
        @(posedge clk);
        #1 drive_port(p, op, a, b, sc);
        wait_accept(p);
        @(negedge clk);
        chk("lat_exec_valid", EW'(bus.rsp_valid), EW'(1'b0));
        @(negedge clk);
        chk("lat_resp_valid", EW'(bus.rsp_valid), EW'(1'b1));
        @(negedge clk);
        chk("cc_after_op", EW'(cc), EW'(exp_cc));
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int t;
        rst           = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_op0   = 2'b00; bus.req_op1 = 2'b00;
        bus.req_a0    = '0; bus.req_a1 = '0; bus.req_b0 = '0; bus.req_b1 = '0;
        bus.req_setcc = 2'b00;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_req_ready", EW'(bus.req_ready), EW'(2'b00));
        chk("reset_state", {EW'(dbg_state), EW'(bus.rsp_valid)} == 2 * EW'(0)
            ? EW'(0) : EW'(1), EW'(0));
        chk("reset_rsp", {bus.rsp_id, bus.rsp_zf, bus.rsp_sf, bus.rsp_of, bus.rsp_y}, EW'(0));
        chk("reset_cc", EW'(cc), EW'(3'b100));
        bus.req_valid = 2'b00;
        @(posedge clk);
        #1 rst = 1'b0;

        // Port0 ADD 1 + -1 = 0
        push(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        run_op(0, 2'b00, 64'd1, -64'sd1, 1'b1, 3'b100);
        // Port1 ADD max + max = -2, overflow
        push(1'b1, -64'sd2, 1'b0, 1'b1, 1'b1);
        run_op(1, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 3'b011);
        // Port0 SUB 0 - min = min, overflow
        push(1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
        run_op(0, 2'b01, 64'd0, 64'h8000_0000_0000_0000, 1'b1, 3'b011);
        // Same operands XOR: OF forced 0 although the ALU reports 1
        push(1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        run_op(0, 2'b11, 64'd0, 64'h8000_0000_0000_0000, 1'b1, 3'b010);

        // Backpressure: port1 AND 0xF0 & 0x3C = 0x30, rsp_ready low 5 cycles
        bus.rsp_ready = 1'b0;
        push(1'b1, 64'h30, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 drive_port(1, 2'b10, 64'hF0, 64'h3C, 1'b1);
        wait_accept(1);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", EW'(bus.rsp_valid), EW'(1'b1));
            chk("bp_y", EW'(bus.rsp_y), EW'(64'h30));
            chk("bp_req_ready", EW'(bus.req_ready), EW'(2'b00));
            chk("bp_cc_hold", EW'(cc), EW'(3'b010));
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_cc_before_hs", EW'(cc), EW'(3'b010));
        @(negedge clk);
        chk("bp_cc_after_hs", EW'(cc), EW'(3'b000));

        // Port0 SUB 5-3=2 without setcc; leaves prio favouring port1
        push(1'b0, 64'd2, 1'b0, 1'b0, 1'b0);
        run_op(0, 2'b01, 64'd5, 64'd3, 1'b0, 3'b000);

        // Reset while in EXEC: op discarded, no response, cc restored
        @(posedge clk);
        #1 drive_port(0, 2'b00, 64'd7, 64'd8, 1'b1);
        wait_accept(0);
        chk("pre_rst_state_exec", EW'(dbg_state), EW'(2'd1));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_exec_state", EW'(dbg_state), EW'(2'd0));
        chk("rst_exec_valid", EW'(bus.rsp_valid), EW'(1'b0));
        chk("rst_exec_cc", EW'(cc), EW'(3'b100));

        // Continuous dual requests: grants 0,1,0,1; port1 op has setcc=0
        push(1'b0, -64'sd2, 1'b0, 1'b1, 1'b0);
        push(1'b1, 64'd0, 1'b1, 1'b0, 1'b0);
        push(1'b0, -64'sd2, 1'b0, 1'b1, 1'b0);
        push(1'b1, 64'd0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive_port(0, 2'b00, 64'd5, -64'sd7, 1'b1);
        drive_port(1, 2'b11, 64'd6, 64'd6, 1'b0);
        for (int k = 0; k < 4; k++) begin
            t = 0;
            while (bus.req_ready == 2'b00 && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("rr_grant", EW'(bus.req_ready), (k % 2 == 0) ? EW'(2'b01) : EW'(2'b10));
            @(posedge clk);
            #1;
            if (k == 3) bus.req_valid = 2'b00;
            t = 0;
            @(negedge clk);
            while (!bus.rsp_valid && t < 20) begin
                @(negedge clk);
                t++;
            end
            @(negedge clk);
            chk("rr_cc", EW'(cc), EW'(3'b010));
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", EW'(exp_q.size()), EW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
